// File: rtl/sram_pkg.sv
// Shared types and constants for the async-SRAM controller.
// The turnaround state is only reached when SRAM_TURNAROUND_EN is defined.
package sram_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StHold,
        StTa
    } state_e;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } pin_ctrl_t;

    localparam pin_ctrl_t PinCtrlIdle = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};

endpackage

// File: rtl/sram_ctrl_if.sv
// Core-side request/response channel of the SRAM controller.
interface sram_ctrl_if #(
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 32
) ();
    localparam int unsigned BW = DW / 8;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_wmask;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_ctrl_pads.sv
// Registered SRAM pin drivers, tristate data buffer and read-data capture register.
module sram_ctrl_pads
    import sram_pkg::*;
#(
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  pin_ctrl_t     ctrl_i,
    input  logic [BW-1:0] be_n_i,
    input  logic [AW-1:0] addr_i,
    input  logic          drive_en_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          sample_en_i,
    output logic [DW-1:0] rdata_o,
    inout  wire  [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic [BW-1:0] ram_be_n,
    output logic          ram_ce_n,
    output logic          ram_oe_n,
    output logic          ram_we_n
);
    pin_ctrl_t     ctrl_q;
    logic [BW-1:0] be_n_q;
    logic [AW-1:0] addr_q;
    logic          drive_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (sample_en_i) rdata_d = ram_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= PinCtrlIdle;
            be_n_q  <= '1;
            addr_q  <= '0;
            drive_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_i;
            be_n_q  <= be_n_i;
            addr_q  <= addr_i;
            drive_q <= drive_en_i;
            wdata_q <= wdata_i;
            rdata_q <= rdata_d;
        end
    end

    assign ram_data = drive_q ? wdata_q : {DW{1'bz}};
    assign ram_addr = addr_q;
    assign ram_be_n = be_n_q;
    assign ram_ce_n = ctrl_q.ce_n;
    assign ram_oe_n = ctrl_q.oe_n;
    assign ram_we_n = ctrl_q.we_n;
    assign rdata_o  = rdata_q;
endmodule

// File: rtl/sram_ctrl.sv
// Async-SRAM controller: valid/ready word requests to chip-pin timing, one bank per instance.
// Define SRAM_TURNAROUND_EN to add a bus turnaround cycle after every write.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned AW      = 20,
    parameter int unsigned DW      = 32,
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_if.slave         bus,
    inout  wire  [DW-1:0]      ram_data,
    output logic [AW-1:0]      ram_addr,
    output logic [DW/8-1:0]    ram_be_n,
    output logic               ram_ce_n,
    output logic               ram_oe_n,
    output logic               ram_we_n
);
    localparam int unsigned BW = DW / 8;
    localparam logic [WAIT_CNT_W-1:0] RdLast = WAIT_CNT_W'(RD_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WrLast = WAIT_CNT_W'(WR_WAIT);

    state_e                state_d, state_q;
    logic [WAIT_CNT_W-1:0] cnt_d, cnt_q;
    logic [AW-1:0]         addr_d, addr_q;
    logic [DW-1:0]         wdata_d, wdata_q;
    logic [BW-1:0]         wmask_d, wmask_q;
    logic                  rsp_valid_d, rsp_valid_q;
    logic                  sample_en;
    pin_ctrl_t             ctrl_d;
    logic [BW-1:0]         be_n_d;
    logic                  drive_d;
    logic [DW-1:0]         rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_valid_d = 1'b0;
        sample_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
                    cnt_d   = '0;
                    state_d = bus.req_we ? StWr : StRd;
                end
            end
            StRd: begin
                if (cnt_q == RdLast) begin
                    sample_en   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + WAIT_CNT_W'(1);
                end
            end
            StWr: begin
                if (cnt_q == WrLast) state_d = StHold;
                else                 cnt_d   = cnt_q + WAIT_CNT_W'(1);
            end
            StHold: begin
`ifdef SRAM_TURNAROUND_EN
                state_d = StTa;
`else
                state_d = StIdle;
`endif
            end
            StTa:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pin values are decoded from the next state so the pad registers line up with it.
    always_comb begin
        ctrl_d  = PinCtrlIdle;
        be_n_d  = '1;
        drive_d = 1'b0;
        unique case (state_d)
            StRd: begin
                ctrl_d.ce_n = 1'b0;
                ctrl_d.oe_n = 1'b0;
                be_n_d      = '0;
            end
            StWr: begin
                ctrl_d.ce_n = 1'b0;
                ctrl_d.we_n = 1'b0;
                be_n_d      = ~wmask_d;
                drive_d     = 1'b1;
            end
            StHold: begin
                ctrl_d.ce_n = 1'b0;
                be_n_d      = ~wmask_d;
                drive_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    sram_ctrl_pads #(
        .AW(AW),
        .DW(DW),
        .BW(BW)
    ) u_pads (
        .clk         (clk),
        .rst         (rst),
        .ctrl_i      (ctrl_d),
        .be_n_i      (be_n_d),
        .addr_i      (addr_d),
        .drive_en_i  (drive_d),
        .wdata_i     (wdata_d),
        .sample_en_i (sample_en),
        .rdata_o     (rdata),
        .ram_data    (ram_data),
        .ram_addr    (ram_addr),
        .ram_be_n    (ram_be_n),
        .ram_ce_n    (ram_ce_n),
        .ram_oe_n    (ram_oe_n),
        .ram_we_n    (ram_we_n)
    );

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata;
endmodule
